// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl -- turns a UART byte stream into framed payload packets.
//
// Frame: SOF_BYTE, LEN, LEN payload bytes[, CHK]. The payload is buffered and
// released over a valid/ready stream only once the whole frame is accepted.
// Bad frames raise o_err for one cycle and bump a saturating error counter.
// Bytes that arrive while the buffer is draining are dropped, and each drop
// pulses o_overrun.
//
// Optional feature: define UART_RX_PKT_CHK_EN to require a trailing CHK byte.
// CHK is the XOR of LEN and all payload bytes. Without the macro the frame
// ends after the last payload byte.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_byte        received byte; i_byte_vld marks it valid for one cycle
//   o_data        payload byte; o_valid/i_ready handshake; o_last on final byte
//   o_err         one-cycle pulse, packet rejected
//   o_overrun     one-cycle pulse, byte dropped while draining
//   o_err_cnt     saturating count of rejected packets
//   o_busy        receiver is not idle
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SOF_BYTE = 8'hA5,
  parameter int unsigned MAX_LEN  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_vld,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_err,
  output logic       o_overrun,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam int unsigned IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DEPTH     = 2 ** IW;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t     state, state_n;
  logic [7:0] len;
  logic [7:0] wr_idx;
  logic [7:0] rd_idx;
  logic [7:0] buffer [DEPTH];
  logic       err_n;
  logic       overrun_n;
  logic       len_ok;
  logic       pay_last;
  logic       rd_last;
  logic       transfer;
`ifdef UART_RX_PKT_CHK_EN
  logic [7:0] xor_acc;
`endif

  assign len_ok   = (i_byte != 8'd0) && (i_byte <= MAX_LEN_B);
  assign pay_last = (wr_idx == len - 8'd1);
  assign rd_last  = (rd_idx == len - 8'd1);
  assign transfer = (state == S_DRAIN) && i_ready;

  always_comb begin
    state_n   = state;
    err_n     = 1'b0;
    overrun_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_byte_vld && (i_byte == SOF_BYTE)) state_n = S_LEN;
      end
      S_LEN: begin
        if (i_byte_vld) begin
          if (len_ok) begin
            state_n = S_PAYLOAD;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_byte_vld && pay_last) begin
`ifdef UART_RX_PKT_CHK_EN
          state_n = S_CHK;
`else
          state_n = S_DRAIN;
`endif
        end
      end
      S_CHK: begin
`ifdef UART_RX_PKT_CHK_EN
        if (i_byte_vld) begin
          if (i_byte == xor_acc) begin
            state_n = S_DRAIN;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
`else
        state_n = S_IDLE;
`endif
      end
      S_DRAIN: begin
        // Every strobe here is lost, including one coinciding with the final
        // transfer, because the FSM only reaches IDLE on the next edge.
        overrun_n = i_byte_vld;
        if (transfer && rd_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
      o_err_cnt <= '0;
`ifdef UART_RX_PKT_CHK_EN
      xor_acc   <= '0;
`endif
    end else begin
      state     <= state_n;
      o_err     <= err_n;
      o_overrun <= overrun_n;
      if (err_n && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      if ((state == S_LEN) && i_byte_vld) begin
        len    <= i_byte;
        wr_idx <= '0;
        rd_idx <= '0;
`ifdef UART_RX_PKT_CHK_EN
        xor_acc <= i_byte;
`endif
      end
      if ((state == S_PAYLOAD) && i_byte_vld) begin
        wr_idx <= wr_idx + 8'd1;
`ifdef UART_RX_PKT_CHK_EN
        xor_acc <= xor_acc ^ i_byte;
`endif
      end
      if (transfer) rd_idx <= rd_idx + 8'd1;
    end
  end

  // Payload storage needs no reset; stale contents are never presented.
  always_ff @(posedge i_clk) begin
    if ((state == S_PAYLOAD) && i_byte_vld) buffer[wr_idx[IW-1:0]] <= i_byte;
  end

  assign o_valid = (state == S_DRAIN);
  assign o_data  = o_valid ? buffer[rd_idx[IW-1:0]] : '0;
  assign o_last  = o_valid && rd_last;
  assign o_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl (works with or without
// UART_RX_PKT_CHK_EN). Packet vectors come from a table; expected payload
// bytes go into a scoreboard queue and are compared as the DUT emits them.
module tb_uart_rx_pkt_ctrl;

  localparam logic [7:0]  SOF  = 8'hA5;
  localparam int unsigned MAXL = 16;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_byte;
  logic       i_byte_vld;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_last;
  logic       o_err;
  logic       o_overrun;
  logic [7:0] o_err_cnt;
  logic       o_busy;

  uart_rx_pkt_ctrl #(.SOF_BYTE(SOF), .MAX_LEN(MAXL)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_byte     (i_byte),
    .i_byte_vld (i_byte_vld),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_err      (o_err),
    .o_overrun  (o_overrun),
    .o_err_cnt  (o_err_cnt),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0]  len;
    int unsigned npay;
    logic [7:0]  pay [MAXL];
    logic        bad_chk;
    logic        exp_err;
  } vec_t;

  exp_t        sb [$];
  vec_t        vecs [$];
  int unsigned n_pass    = 0;
  int unsigned n_total   = 0;
  int unsigned err_seen  = 0;
  int unsigned exp_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output monitor: consumes the scoreboard on every handshake.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_err) err_seen++;
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(o_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(o_data), 32'(e.data));
          check("out_last", 32'(o_last), 32'(e.last));
        end
      end else if (!o_valid) begin
        check("idle_outputs_zero", {23'd0, o_data, o_last}, 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_byte     = b;
    i_byte_vld = 1'b1;
  endtask

  task automatic release_bus();
    @(posedge i_clk); #1;
    i_byte     = '0;
    i_byte_vld = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [7:0] len, input int unsigned npay,
                               input logic [7:0] seed, input logic bad, input logic err);
    vec_t v;
    v.len     = len;
    v.npay    = npay;
    v.bad_chk = bad;
    v.exp_err = err;
    for (int j = 0; j < int'(MAXL); j++) v.pay[j] = seed + 8'(j) * 8'h11;
    return v;
  endfunction

  task automatic send_vec(input vec_t v);
    logic [7:0] chk;
    chk = v.len;
    if (!v.exp_err)
      for (int j = 0; j < int'(v.npay); j++)
        sb.push_back('{data: v.pay[j], last: (j == int'(v.npay) - 1)});
    send_byte(SOF);
    send_byte(v.len);
    for (int j = 0; j < int'(v.npay); j++) begin
      send_byte(v.pay[j]);
      chk = chk ^ v.pay[j];
    end
`ifdef UART_RX_PKT_CHK_EN
    if (v.npay > 0) send_byte(v.bad_chk ? (chk ^ 8'hFF) : chk);
`endif
    release_bus();
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge i_clk);
      if (!o_busy && sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check("drain_timeout", 32'(sb.size()) + 32'(o_busy), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned e0;
    i_rst      = 1'b1;
    i_byte     = '0;
    i_byte_vld = 1'b0;
    i_ready    = 1'b1;

    vecs.push_back(mkv(8'd3,   3,  8'h11, 1'b0, 1'b0));
    vecs.push_back(mkv(8'd2,   2,  8'hAA, 1'b0, 1'b0));
    vecs.push_back(mkv(8'd1,   1,  8'hA5, 1'b0, 1'b0));
    vecs.push_back(mkv(8'd0,   0,  8'h00, 1'b0, 1'b1));
    vecs.push_back(mkv(8'd17,  0,  8'h00, 1'b0, 1'b1));
    vecs.push_back(mkv(8'd16,  16, 8'h01, 1'b0, 1'b0));
    vecs.push_back(mkv(8'd255, 0,  8'h00, 1'b0, 1'b1));
    vecs.push_back(mkv(8'd4,   4,  8'h0F, 1'b0, 1'b0));
`ifdef UART_RX_PKT_CHK_EN
    vecs.push_back(mkv(8'd2,   2,  8'h10, 1'b1, 1'b1));
`endif

    // Reset values
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy",    32'(o_busy),    32'd0);
    check("rst_valid",   32'(o_valid),   32'd0);
    check("rst_err",     32'(o_err),     32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    check("rst_data",    {23'd0, o_data, o_last}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Non-SOF byte in IDLE is ignored silently
    send_byte(8'h3C);
    release_bus();
    @(negedge i_clk);
    check("junk_busy", 32'(o_busy), 32'd0);
    check("junk_err",  32'(o_err),  32'd0);

    // Reset mid-packet discards it without an error
    send_byte(SOF);
    send_byte(8'h04);
    send_byte(8'h01);
    @(posedge i_clk); #1;
    i_byte_vld = 1'b0;
    i_rst      = 1'b1;
    check("midpkt_busy", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_mid_busy",    32'(o_busy),    32'd0);
    check("rst_mid_err",     32'(o_err),     32'd0);
    check("rst_mid_err_cnt", 32'(o_err_cnt), 32'd0);

    // Table-driven packets
    for (int i = 0; i < vecs.size(); i++) begin
      e0 = err_seen;
      if (vecs[i].exp_err) exp_cnt++;
      send_vec(vecs[i]);
      wait_idle();
      @(posedge i_clk); #1;
      check($sformatf("vec%0d_err_pulses", i), err_seen - e0, 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_err_cnt", i), 32'(o_err_cnt), exp_cnt);
      check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'd0);
    end

    // Error pulse timing: illegal LEN
    send_byte(SOF);
    send_byte(8'h00);
    release_bus();
    exp_cnt++;
    @(negedge i_clk);
    check("len0_err_pulse", 32'(o_err),     32'd1);
    check("len0_err_cnt",   32'(o_err_cnt), exp_cnt);
    @(negedge i_clk);
    check("len0_err_width", 32'(o_err),  32'd0);
    check("len0_idle",      32'(o_busy), 32'd0);

`ifdef UART_RX_PKT_CHK_EN
    // Error pulse timing: checksum mismatch
    send_byte(SOF);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h00);
    release_bus();
    exp_cnt++;
    @(negedge i_clk);
    check("chk_err_pulse", 32'(o_err),     32'd1);
    check("chk_err_cnt",   32'(o_err_cnt), exp_cnt);
    check("chk_no_valid",  32'(o_valid),   32'd0);
    @(negedge i_clk);
    check("chk_err_width", 32'(o_err),  32'd0);
    check("chk_idle",      32'(o_busy), 32'd0);
`endif

    // Back-pressure with an overrun byte, then a drop on the final transfer
    i_ready = 1'b0;
    send_vec(mkv(8'd2, 2, 8'h66, 1'b0, 1'b0));
    @(negedge i_clk);
    check("bp_valid", 32'(o_valid), 32'd1);
    check("bp_data",  32'(o_data),  32'h66);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      i_byte     = 8'h55;
      i_byte_vld = (k == 1);
      @(negedge i_clk);
      check($sformatf("bp_hold_data%0d", k), 32'(o_data),  32'h66);
      check($sformatf("bp_hold_last%0d", k), 32'(o_last),  32'd0);
      check($sformatf("bp_hold_vld%0d", k),  32'(o_valid), 32'd1);
      if (k == 2) check("bp_overrun_pulse", 32'(o_overrun), 32'd1);
      if (k == 3) check("bp_overrun_width", 32'(o_overrun), 32'd0);
    end
    @(posedge i_clk); #1;
    i_byte_vld = 1'b0;
    i_ready    = 1'b1;
    @(posedge i_clk); #1;
    i_byte     = SOF;
    i_byte_vld = 1'b1;
    @(posedge i_clk); #1;
    i_byte_vld = 1'b0;
    @(negedge i_clk);
    check("last_xfer_overrun", 32'(o_overrun), 32'd1);
    check("last_xfer_busy",    32'(o_busy),    32'd0);
    check("last_xfer_valid",   32'(o_valid),   32'd0);
    check("last_xfer_sb",      32'(sb.size()), 32'd0);
    check("overrun_err_cnt",   32'(o_err_cnt), exp_cnt);

    // Packet after the drops still arrives intact
    send_vec(mkv(8'd3, 3, 8'h21, 1'b0, 1'b0));
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
